timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Playback-time controller for the music player's mm:ss timer. It turns user commands (play/pause, stop, skip forward/back) into the timer's `count` run-enable and `adder` seek offset. It derives the 1-second tick from the system clock and keeps the authoritative elapsed-seconds value. It flags end-of-track against a per-track length. It sits between the button/command decoder and the `Timer` display datapath.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clock cycles per counted second (≥2).
- `SKIP_SEC`, 10: seconds moved per skip command (1..63).

Ports:
- `clk`  in  1: system clock; every register updates on its rising edge.
- `reset`  in  1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `play_pause`  in  1: single-cycle pulse; toggles play/pause, or starts playback.
- `stop`  in  1: single-cycle pulse; returns to IDLE and clears all time.
- `skip_fwd`  in  1: single-cycle pulse; adds `SKIP_SEC` to the offset.
- `skip_back`  in  1: single-cycle pulse; subtracts `SKIP_SEC` from the offset.
- `track_len`  in  10: track length in seconds; must be stable while not IDLE.
- `count`  out  1: timer run-enable.
- `adder`  out  6: seek offset in seconds, fed to the Timer.
- `elapsed`  out  11: `played + adder`, where `played` is the 10-bit count of seconds actually played.
- `sec_tick`  out  1: one-cycle pulse per counted second.
- `state`  out  2: IDLE=0, PLAYING=1, PAUSED=2, DONE=3.
- `track_done`  out  1: one-cycle pulse on entry to DONE.

## Operation
- Registers: `state`, `played`[9:0], `adder`[5:0], prescaler `pre` (0..TICK_DIV-1), `track_done`.
- Command priority when several commands arrive in the same cycle:
  - `stop` beats `play_pause`, which beats skips.
  - `skip_fwd` together with `skip_back` is ignored.
  - A command losing to a higher-priority one is dropped, not queued.
- IDLE:
  - `count`=0.
  - `play_pause` with `track_len`≠0 → PLAYING.
  - `play_pause` with `track_len`=0 is ignored.
  - Skips are ignored.
- PLAYING:
  - `count`=1.
  - `pre` increments each cycle.
  - When `pre`=TICK_DIV-1: `pre`←0, `sec_tick`=1, and `played` increments, saturating at 1023.
  - `play_pause` → PAUSED.
- PAUSED:
  - `count`=0.
  - `pre` and `played` are held, not cleared.
  - `play_pause` → PLAYING; counting resumes from the held `pre`.
- DONE:
  - `count`=0; all counters are held.
  - `play_pause` → PLAYING with `played`, `adder` and `pre` cleared (restart).
  - Skips are ignored.
- `stop`, from any state → IDLE; clears `played`, `adder` and `pre`.
- Skips, accepted only in PLAYING or PAUSED:
  - Forward: `adder` ← min(`adder`+SKIP_SEC, 63).
  - Back: `adder` ← max(`adder`-SKIP_SEC, 0).
  - Saturation is silent.
  - Skips never change `played` or `pre`.
- End detection:
  - Condition: in PLAYING or PAUSED, registered `elapsed` ≥ `track_len`, as an 11-bit unsigned compare.
  - Effect: next state is DONE and `track_done` pulses for exactly one cycle.
  - A forward skip past the end while paused also ends the track.
  - End detection takes priority over `play_pause` and skips in the same cycle. It does not take priority over `stop`.
- `elapsed` is purely combinational from the `played` and `adder` registers.

## Timing
- Reset values:
  - `state`=IDLE, `played`=0, `adder`=0, `pre`=0.
  - `count`=0, `sec_tick`=0, `track_done`=0, `elapsed`=0.
- `count` is decoded from registered `state`. It goes high the cycle after `play_pause` is sampled in IDLE, and low the cycle after it is sampled in PLAYING.
- First `sec_tick` comes TICK_DIV cycles after `count` rises. `played` shows the increment on the following cycle.
- Skip latency: one cycle from the sampled pulse to the updated `adder`/`elapsed`.
- End latency:
  - `elapsed` reaches `track_len` at edge N.
  - DONE is entered and `track_done`=1 at edge N+1.
  - `count`=0 from edge N+1 onward.
- `sec_tick` is never asserted outside PLAYING. A wrap on the same edge as a pause is counted, and the pause then takes effect.
- `reset` overrides everything in the cycle it is sampled, mid-second or mid-skip included.

## Test plan
Use `TICK_DIV`=4 and `SKIP_SEC`=10 for simulation.
1. Reset then idle: `track_len`=20, no commands for 10 cycles → `state`=0, `count`=0, `elapsed`=0, `adder`=0, no `sec_tick`.
2. Play and count: `play_pause` pulse with `track_len`=20 → `count`=1 next cycle. `sec_tick` every 4 cycles. `elapsed`=3 after 12 PLAYING cycles.
3. Pause and hold: pause 2 cycles into a second, wait 20 cycles → `elapsed` unchanged. Resume → next `sec_tick` after exactly 2 cycles.
4. Skip saturation: 7× `skip_fwd` with `track_len`=1000 → `adder`=63. Then 8× `skip_back` → `adder`=0; `played` unaffected throughout.
5. End of track: `track_len`=5, play, 1 second elapses, then `skip_fwd` → `elapsed`=11. DONE and one-cycle `track_done` the next cycle; `count`=0. `play_pause` → restart with `elapsed`=0.
6. Simultaneous events: `stop`+`play_pause` in PLAYING → IDLE and all cleared. `skip_fwd`+`skip_back` together → `adder` unchanged. `reset` mid-second → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Command and status bundle between the command decoder, timer_ctrl and the Timer datapath.
interface timer_ctrl_if;
    logic        play_pause;
    logic        stop;
    logic        skip_fwd;
    logic        skip_back;
    logic [9:0]  track_len;
    logic        count;
    logic [5:0]  adder;
    logic [10:0] elapsed;
    logic        sec_tick;
    logic [1:0]  state;
    logic        track_done;

    modport master (
        output play_pause, stop, skip_fwd, skip_back, track_len,
        input  count, adder, elapsed, sec_tick, state, track_done
    );

    modport slave (
        input  play_pause, stop, skip_fwd, skip_back, track_len,
        output count, adder, elapsed, sec_tick, state, track_done
    );
endinterface

// File: rtl/timer_ctrl.sv
// Playback-time controller: turns play/pause/stop/skip commands into the Timer run-enable
// and seek offset, derives the 1 s tick and flags end-of-track.
module timer_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SKIP_SEC = 10
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PLAYED_W = 10;
    localparam int unsigned ADDER_W  = 6;
    localparam int unsigned ELAP_W   = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PLAYED_W-1:0]   played_q, played_d;
    logic [ADDER_W-1:0]    adder_q, adder_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic                  track_done_q, track_done_d;

    logic [ELAP_W-1:0]     elapsed_c;
    logic                  running_c;
    logic                  end_hit_c;
    logic                  wrap_c;
    logic                  skip_ok_c;
    logic [ADDER_W:0]      fwd_sum_c;

    assign elapsed_c = ELAP_W'(played_q) + ELAP_W'(adder_q);
    assign running_c = (state_q == PLAYING) || (state_q == PAUSED);
    assign end_hit_c = running_c && (elapsed_c >= ELAP_W'(bus.track_len));
    // Counting freezes on the end-detect cycle so the value shown in DONE is the one that ended it.
    assign wrap_c    = (state_q == PLAYING) && !end_hit_c && (pre_q == PRE_W'(TICK_DIV - 1));
    assign skip_ok_c = running_c && !end_hit_c && !bus.play_pause && (bus.skip_fwd ^ bus.skip_back);
    assign fwd_sum_c = (ADDER_W+1)'(adder_q) + (ADDER_W+1)'(SKIP_SEC);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            played_q     <= '0;
            adder_q      <= '0;
            pre_q        <= '0;
            track_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            played_q     <= played_d;
            adder_q      <= adder_d;
            pre_q        <= pre_d;
            track_done_q <= track_done_d;
        end
    end

    // Next-state, counter and offset logic; stop beats end detection, which beats everything else.
    always_comb begin
        state_d      = state_q;
        played_d     = played_q;
        adder_d      = adder_q;
        pre_d        = pre_q;
        track_done_d = 1'b0;

        if (bus.stop) begin
            state_d  = IDLE;
            played_d = '0;
            adder_d  = '0;
            pre_d    = '0;
        end else if (end_hit_c) begin
            state_d      = DONE;
            track_done_d = 1'b1;
        end else begin
            if (state_q == PLAYING) begin
                if (wrap_c) begin
                    pre_d = '0;
                    if (played_q != {PLAYED_W{1'b1}}) begin
                        played_d = played_q + PLAYED_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.play_pause && (bus.track_len != '0)) begin
                        state_d = PLAYING;
                    end
                end
                PLAYING: begin
                    if (bus.play_pause) begin
                        state_d = PAUSED;
                    end
                end
                PAUSED: begin
                    if (bus.play_pause) begin
                        state_d = PLAYING;
                    end
                end
                DONE: begin
                    if (bus.play_pause) begin
                        state_d  = PLAYING;
                        played_d = '0;
                        adder_d  = '0;
                        pre_d    = '0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (skip_ok_c) begin
                if (bus.skip_fwd) begin
                    adder_d = (fwd_sum_c > (ADDER_W+1)'({ADDER_W{1'b1}})) ? {ADDER_W{1'b1}}
                                                                           : ADDER_W'(fwd_sum_c);
                end else begin
                    adder_d = (adder_q < ADDER_W'(SKIP_SEC)) ? '0 : (adder_q - ADDER_W'(SKIP_SEC));
                end
            end
        end
    end

    assign bus.count      = (state_q == PLAYING);
    assign bus.state      = state_q;
    assign bus.adder      = adder_q;
    assign bus.elapsed    = elapsed_c;
    assign bus.sec_tick   = wrap_c;
    assign bus.track_done = track_done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with TICK_DIV=4, SKIP_SEC=10.
module tb_timer_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    timer_ctrl_if bus();

    timer_ctrl #(
        .TICK_DIV(4),
        .SKIP_SEC(10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        bus.play_pause = 1'b0;
        bus.stop       = 1'b0;
        bus.skip_fwd   = 1'b0;
        bus.skip_back  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.track_len = 10'd20;
        step();
        reset = 1'b0;
        n_checks++;
        if (bus.state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        n_checks++;
        if (bus.count !== 1'b0) begin n_fail++; $display("FAIL reset_count: got %0b expected 0", bus.count); end
        n_checks++;
        if (bus.elapsed !== 11'd0) begin n_fail++; $display("FAIL reset_elapsed: got %0d expected 0", bus.elapsed); end
        n_checks++;
        if (bus.track_done !== 1'b0) begin n_fail++; $display("FAIL reset_track_done: got %0b expected 0", bus.track_done); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (bus.sec_tick !== 1'b0 || bus.state !== 2'd0) begin
                n_fail++;
                $display("FAIL idle_quiet[%0d]: sec_tick=%0b state=%0d expected 0/0", i, bus.sec_tick, bus.state);
            end
        end
        n_checks++;
        if (bus.adder !== 6'd0 || bus.elapsed !== 11'd0) begin
            n_fail++; $display("FAIL idle_time: adder=%0d elapsed=%0d expected 0/0", bus.adder, bus.elapsed);
        end
    endtask

    task automatic test_play_count();
        bus.track_len  = 10'd20;
        bus.play_pause = 1'b1;
        step();
        bus.play_pause = 1'b0;
        n_checks++;
        if (bus.count !== 1'b1 || bus.state !== 2'd1) begin
            n_fail++; $display("FAIL play_start: count=%0b state=%0d expected 1/1", bus.count, bus.state);
        end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (bus.sec_tick !== ((i % 4) == 3)) begin
                n_fail++; $display("FAIL sec_tick_cycle[%0d]: got %0b expected %0b", i, bus.sec_tick, (i % 4) == 3);
            end
            step();
        end
        n_checks++;
        if (bus.elapsed !== 11'd3) begin n_fail++; $display("FAIL play_elapsed: got %0d expected 3", bus.elapsed); end
    endtask

    task automatic test_pause_hold();
        step();
        bus.play_pause = 1'b1;
        step();
        bus.play_pause = 1'b0;
        n_checks++;
        if (bus.state !== 2'd2 || bus.count !== 1'b0) begin
            n_fail++; $display("FAIL pause_enter: state=%0d count=%0b expected 2/0", bus.state, bus.count);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (bus.elapsed !== 11'd3 || bus.sec_tick !== 1'b0) begin
                n_fail++; $display("FAIL pause_hold[%0d]: elapsed=%0d sec_tick=%0b expected 3/0", i, bus.elapsed, bus.sec_tick);
            end
        end
        bus.play_pause = 1'b1;
        step();
        bus.play_pause = 1'b0;
        n_checks++;
        if (bus.sec_tick !== 1'b0 || bus.count !== 1'b1) begin
            n_fail++; $display("FAIL resume_first: sec_tick=%0b count=%0b expected 0/1", bus.sec_tick, bus.count);
        end
        step();
        n_checks++;
        if (bus.sec_tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick: got %0b expected 1", bus.sec_tick); end
        step();
        n_checks++;
        if (bus.elapsed !== 11'd4) begin n_fail++; $display("FAIL resume_elapsed: got %0d expected 4", bus.elapsed); end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_checks++;
        if (bus.state !== 2'd0 || bus.elapsed !== 11'd0) begin
            n_fail++; $display("FAIL stop_clear: state=%0d elapsed=%0d expected 0/0", bus.state, bus.elapsed);
        end
    endtask

    task automatic test_skip_sat();
        logic [5:0] fwd_exp  [7];
        logic [5:0] back_exp [8];
        fwd_exp  = '{6'd10, 6'd20, 6'd30, 6'd40, 6'd50, 6'd60, 6'd63};
        back_exp = '{6'd53, 6'd43, 6'd33, 6'd23, 6'd13, 6'd3, 6'd0, 6'd0};
        bus.track_len  = 10'd1000;
        bus.play_pause = 1'b1;
        step();
        step();
        bus.play_pause = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.skip_fwd = 1'b1;
            step();
            bus.skip_fwd = 1'b0;
            n_checks++;
            if (bus.adder !== fwd_exp[i] || bus.elapsed !== 11'(fwd_exp[i])) begin
                n_fail++; $display("FAIL skip_fwd[%0d]: adder=%0d elapsed=%0d expected %0d", i, bus.adder, bus.elapsed, fwd_exp[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            bus.skip_back = 1'b1;
            step();
            bus.skip_back = 1'b0;
            n_checks++;
            if (bus.adder !== back_exp[i] || bus.elapsed !== 11'(back_exp[i])) begin
                n_fail++; $display("FAIL skip_back[%0d]: adder=%0d elapsed=%0d expected %0d", i, bus.adder, bus.elapsed, back_exp[i]);
            end
        end
        n_checks++;
        if (bus.state !== 2'd2) begin n_fail++; $display("FAIL skip_state: got %0d expected 2", bus.state); end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic test_end_of_track();
        bus.track_len  = 10'd5;
        bus.play_pause = 1'b1;
        step();
        bus.play_pause = 1'b0;
        repeat (4) step();
        n_checks++;
        if (bus.elapsed !== 11'd1) begin n_fail++; $display("FAIL end_one_sec: got %0d expected 1", bus.elapsed); end
        bus.skip_fwd = 1'b1;
        step();
        bus.skip_fwd = 1'b0;
        n_checks++;
        if (bus.elapsed !== 11'd11 || bus.state !== 2'd1 || bus.track_done !== 1'b0) begin
            n_fail++; $display("FAIL end_skip: elapsed=%0d state=%0d track_done=%0b expected 11/1/0", bus.elapsed, bus.state, bus.track_done);
        end
        step();
        n_checks++;
        if (bus.state !== 2'd3 || bus.track_done !== 1'b1 || bus.count !== 1'b0) begin
            n_fail++; $display("FAIL end_done: state=%0d track_done=%0b count=%0b expected 3/1/0", bus.state, bus.track_done, bus.count);
        end
        step();
        n_checks++;
        if (bus.track_done !== 1'b0 || bus.state !== 2'd3 || bus.elapsed !== 11'd11) begin
            n_fail++; $display("FAIL end_pulse_once: track_done=%0b state=%0d elapsed=%0d expected 0/3/11", bus.track_done, bus.state, bus.elapsed);
        end
        bus.play_pause = 1'b1;
        step();
        bus.play_pause = 1'b0;
        n_checks++;
        if (bus.state !== 2'd1 || bus.elapsed !== 11'd0 || bus.count !== 1'b1) begin
            n_fail++; $display("FAIL end_restart: state=%0d elapsed=%0d count=%0b expected 1/0/1", bus.state, bus.elapsed, bus.count);
        end
    endtask

    task automatic test_simultaneous();
        step();
        step();
        bus.stop       = 1'b1;
        bus.play_pause = 1'b1;
        step();
        clear_cmds();
        n_checks++;
        if (bus.state !== 2'd0 || bus.elapsed !== 11'd0 || bus.count !== 1'b0) begin
            n_fail++; $display("FAIL stop_beats_pp: state=%0d elapsed=%0d count=%0b expected 0/0/0", bus.state, bus.elapsed, bus.count);
        end
        bus.track_len  = 10'd1000;
        bus.play_pause = 1'b1;
        step();
        step();
        bus.play_pause = 1'b0;
        bus.skip_fwd   = 1'b1;
        step();
        bus.skip_back  = 1'b1;
        step();
        clear_cmds();
        n_checks++;
        if (bus.adder !== 6'd10) begin n_fail++; $display("FAIL both_skips: adder=%0d expected 10", bus.adder); end
        bus.play_pause = 1'b1;
        bus.skip_fwd   = 1'b1;
        step();
        clear_cmds();
        n_checks++;
        if (bus.adder !== 6'd10 || bus.state !== 2'd1) begin
            n_fail++; $display("FAIL pp_beats_skip: adder=%0d state=%0d expected 10/1", bus.adder, bus.state);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (bus.state !== 2'd0 || bus.count !== 1'b0 || bus.elapsed !== 11'd0 || bus.adder !== 6'd0
            || bus.sec_tick !== 1'b0 || bus.track_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: state=%0d count=%0b elapsed=%0d adder=%0d expected all 0",
                               bus.state, bus.count, bus.elapsed, bus.adder);
        end
        bus.track_len  = 10'd0;
        bus.play_pause = 1'b1;
        step();
        bus.play_pause = 1'b0;
        n_checks++;
        if (bus.state !== 2'd0) begin n_fail++; $display("FAIL zero_len_play: state=%0d expected 0", bus.state); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.track_len = 10'd20;
        clear_cmds();
        test_reset();
        test_play_count();
        test_pause_hold();
        test_skip_sat();
        test_end_of_track();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
